// File: rtl/motion_est_core.sv
// Full-search 16x16 block matcher over a 32x32 window, two candidates per pass.
// Define ME_EARLY_EXIT_EN to stop as soon as a pass finds a zero-SAD match.
module motion_est_core #(
  parameter int PIXEL_W = 8,
  parameter int ACC_W   = 16,
  parameter int DIST_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PIXEL_W-1:0] R,
  input  logic [PIXEL_W-1:0] S1,
  input  logic [PIXEL_W-1:0] S2,
  output logic [7:0]         AddressR,
  output logic [9:0]         AddressS1,
  output logic [9:0]         AddressS2,
  output logic [DIST_W-1:0]  BestDist,
  output logic [3:0]         motionX,
  output logic [3:0]         motionY,
  output logic               completed
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]         k;
  logic [2:0]         oxi;
  logic [3:0]         oy;
  logic               dcnt;
  logic               dv;
  logic [ACC_W-1:0]   acc1, acc2, minv;
  logic [PIXEL_W-1:0] ad1, ad2;
  logic [ACC_W-1:0]   m1, m2;
  logic               lt1, lt2;
  logic               cmp, last, ez, accept, act;
  logic [DIST_W-1:0]  sat;
  logic [3:0]         ox;
  logic [4:0]         wy, wx1, wx2;

  assign ox  = {oxi, 1'b0};
  assign wy  = {1'b0, oy} + {1'b0, k[7:4]};
  assign wx1 = {1'b0, ox} + {1'b0, k[3:0]};
  assign wx2 = wx1 + 5'd1;
  assign act = (state == RUN) || (state == DRAIN);

  assign AddressR  = act ? k : 8'd0;
  assign AddressS1 = act ? {wy, wx1} : 10'd0;
  assign AddressS2 = act ? {wy, wx2} : 10'd0;
  assign completed = (state == DONE);

  assign ad1 = (R > S1) ? R - S1 : S1 - R;
  assign ad2 = (R > S2) ? R - S2 : S2 - R;

  // S1 is ahead of S2 in scan order, so it is compared first
  assign lt1 = acc1 < minv;
  assign m1  = lt1 ? acc1 : minv;
  assign lt2 = acc2 < m1;
  assign m2  = lt2 ? acc2 : m1;
  assign sat = (|m2[ACC_W-1:DIST_W]) ? '1 : m2[DIST_W-1:0];

  assign cmp    = (state == DRAIN) && dcnt;
  assign last   = (oy == 4'hF) && (oxi == 3'h7);
  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef ME_EARLY_EXIT_EN
  assign ez = (m2 == '0);
`else
  assign ez = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (k == 8'hFF) state_n = DRAIN;
      DRAIN:   if (dcnt) state_n = (last || ez) ? DONE : RUN;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      oxi      <= '0;
      oy       <= '0;
      dcnt     <= 1'b0;
      dv       <= 1'b0;
      acc1     <= '0;
      acc2     <= '0;
      minv     <= '1;
      BestDist <= '1;
      motionX  <= '0;
      motionY  <= '0;
    end else begin
      state <= state_n;
      dv    <= (state == RUN);
      if (dv) begin
        acc1 <= acc1 + ACC_W'(ad1);
        acc2 <= acc2 + ACC_W'(ad2);
      end
      if (accept) begin
        k        <= '0;
        oxi      <= '0;
        oy       <= '0;
        dcnt     <= 1'b0;
        acc1     <= '0;
        acc2     <= '0;
        minv     <= '1;
        BestDist <= '1;
        motionX  <= '0;
        motionY  <= '0;
      end else if (state == RUN) begin
        if (k != 8'hFF) k <= k + 8'd1;
      end else if (state == DRAIN) begin
        dcnt <= ~dcnt;
        if (cmp) begin
          minv     <= m2;
          BestDist <= sat;
          if (lt2) begin
            motionX <= {~oxi[2], oxi[1:0], 1'b1};
            motionY <= {~oy[3], oy[2:0]};
          end else if (lt1) begin
            motionX <= {~oxi[2], oxi[1:0], 1'b0};
            motionY <= {~oy[3], oy[2:0]};
          end
          acc1 <= '0;
          acc2 <= '0;
          k    <= '0;
          if (state_n == DONE) {oy, oxi} <= '0;
          else {oy, oxi} <= {oy, oxi} + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_motion_est_core.sv
// Bench for motion_est_core: clocked ROM models, software full-search
// reference pushed to a scoreboard, popped when completed rises.
module tb_motion_est_core;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] d;
    int         lat;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] R, S1, S2;
  logic [7:0] AddressR;
  logic [9:0] AddressS1, AddressS2;
  logic [7:0] BestDist;
  logic [3:0] motionX, motionY;
  logic       completed;

  logic [7:0] rmem [256];
  logic [7:0] smem [1024];

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   ecnt = 0;

  motion_est_core dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .R         (R),
    .S1        (S1),
    .S2        (S2),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .BestDist  (BestDist),
    .motionX   (motionX),
    .motionY   (motionY),
    .completed (completed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    R  <= rmem[AddressR];
    S1 <= smem[AddressS1];
    S2 <= smem[AddressS2];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    ecnt++;
    #1;
  endtask

  function automatic exp_t model();
    exp_t e;
    int best, bx, by, p0, sad, d, ox;
    best = 65535;
    bx = 0;
    by = 0;
    p0 = -1;
    for (int oy = 0; oy < 16; oy++) begin
      for (int oxe = 0; oxe < 16; oxe += 2) begin
        for (int j = 0; j < 2; j++) begin
          ox = oxe + j;
          sad = 0;
          for (int kk = 0; kk < 256; kk++) begin
            d = int'(rmem[kk]) -
                int'(smem[(oy + kk / 16) * 32 + ox + kk % 16]);
            sad += (d < 0) ? -d : d;
          end
          if (sad < best) begin
            best = sad;
            bx = ox;
            by = oy;
          end
        end
        if (best == 0 && p0 < 0) p0 = oy * 8 + oxe / 2;
      end
    end
    e.x = 4'(bx + 8);
    e.y = 4'(by + 8);
    e.d = (best > 255) ? 8'hFF : 8'(best);
    e.lat = 128 * 258;
`ifdef ME_EARLY_EXIT_EN
    if (p0 >= 0) e.lat = 258 * (p0 + 1);
`endif
    return e;
  endfunction

  task automatic load_t4();
    for (int i = 0; i < 256; i++) rmem[i] = 8'h40;
    for (int i = 0; i < 1024; i++) smem[i] = 8'h00;
    for (int r = 0; r < 16; r++) begin
      smem[(5 + r) * 32 + 2] = 8'h41;
      for (int c = 0; c < 16; c++) smem[(5 + r) * 32 + 3 + c] = 8'h40;
    end
  endtask

  task automatic load_t3();
    for (int i = 0; i < 256; i++) rmem[i] = 8'h80;
    for (int i = 0; i < 1024; i++) smem[i] = 8'h00;
  endtask

  task automatic begin_search();
    start = 1'b1;
    step();
    start = 1'b0;
    ecnt = 0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    while (!completed && ecnt < 40000) step();
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, ecnt, e.lat);
      check({tag, "_dist"}, BestDist, e.d);
      check({tag, "_mx"}, motionX, e.x);
      check({tag, "_my"}, motionY, e.y);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) smem[i] = 8'h00;
    repeat (2) step();
    check("rst_done", completed, 0);
    check("rst_dist", BestDist, 8'hFF);
    check("rst_mx", motionX, 0);
    check("rst_my", motionY, 0);
    check("rst_ar", AddressR, 0);
    check("rst_as1", AddressS1, 0);
    check("rst_as2", AddressS2, 0);
    reset = 1'b0;
    step();

    load_t4();
    begin_search();
    while (ecnt < 999) step();
    reset = 1'b1;
    step();
    check("abort_done", completed, 0);
    check("abort_dist", BestDist, 8'hFF);
    check("abort_ar", AddressR, 0);
    check("abort_as1", AddressS1, 0);
    check("abort_as2", AddressS2, 0);
    reset = 1'b0;
    step();

    sb.push_back(model());
    begin_search();
    check("e0_ar", AddressR, 0);
    check("e0_as1", AddressS1, 0);
    check("e0_as2", AddressS2, 1);
    while (ecnt < 17) step();
    check("e17_ar", AddressR, 17);
    check("e17_as1", AddressS1, 33);
    check("e17_as2", AddressS2, 34);
    while (ecnt < 257) step();
    check("drain_ar", AddressR, 255);
    check("drain_as1", AddressS1, 495);
    check("drain_as2", AddressS2, 496);
    check("drain_done", completed, 0);
    while (ecnt < 259) step();
    check("p1_ar", AddressR, 1);
    check("p1_as1", AddressS1, 3);
    check("p1_as2", AddressS2, 4);
    wait_done("odd");
    check("odd_done_ar", AddressR, 0);
    check("odd_done_as2", AddressS2, 0);

    load_t3();
    sb.push_back(model());
    start = 1'b1;
    step();
    ecnt = 0;
    check("restart_drop", completed, 0);
    start = 1'b0;
    wait_done("sat");
    step();
    step();
    check("hold_done", completed, 1);
    check("hold_dist", BestDist, 8'hFF);
    check("hold_mx", motionX, 4'h8);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
